// File: rtl/rng_pkg.sv
// Shared types and constants for the rng_bank random-word generator.
package rng_pkg;

    localparam int unsigned RNG_W         = 16;
    localparam int unsigned RNG_NUM_DRAWS = 9;
    localparam int unsigned RNG_CNT_W     = 4;
    localparam logic [RNG_W-1:0] RNG_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } rng_state_e;

    // One Galois right-shift step
    function automatic logic [RNG_W-1:0] lfsr_step(input logic [RNG_W-1:0] v);
        return (v >> 1) ^ (v[0] ? RNG_TAPS : RNG_W'(0));
    endfunction

    // All-zero is the LFSR lock-up state, so map it to 1
    function automatic logic [RNG_W-1:0] lfsr_nz(input logic [RNG_W-1:0] v);
        return (v == RNG_W'(0)) ? RNG_W'(1) : v;
    endfunction

endpackage

// File: rtl/rng_bank_if.sv
// Deal request and drawn-word bus between rng_bank and the card-generation stage.
interface rng_bank_if;

    logic        start;
    logic [15:0] random_number1;
    logic [15:0] random_number2;
    logic [15:0] random_number3;
    logic [15:0] random_number4;
    logic [15:0] random_number5;
    logic [15:0] random_number6;
    logic [15:0] random_number7;
    logic [15:0] random_number8;
    logic [15:0] random_number9;
    logic        work_done_rng;

    modport master (
        output start,
        input  random_number1, random_number2, random_number3,
        input  random_number4, random_number5, random_number6,
        input  random_number7, random_number8, random_number9,
        input  work_done_rng
    );

    modport slave (
        input  start,
        output random_number1, random_number2, random_number3,
        output random_number4, random_number5, random_number6,
        output random_number7, random_number8, random_number9,
        output work_done_rng
    );

endinterface

// File: rtl/rng_bank_lfsr16.sv
// 16-bit Galois LFSR with synchronous load, step enable and zero-lock guard.
module lfsr16
    import rng_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);

    localparam logic [15:0] RESET_NZ = lfsr_nz(RESET_VAL);

    // Load wins over step; a zero load value is forced to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_NZ;
        end else if (load) begin
            q <= lfsr_nz(load_val);
        end else if (en) begin
            q <= lfsr_step(lfsr_nz(q));
        end
    end

endmodule

// File: rtl/rng_bank.sv
// Draws nine 16-bit LFSR words per deal request and flags completion.
// Optional macro RNG_FREE_RUN_EN: LFSR free-runs and SEED keeps its value.
module rng_bank
    import rng_pkg::*;
#(
    parameter logic [15:0]  SEED = 16'hACE1,
    parameter int unsigned  STEP = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    rng_bank_if.slave   bus
);

    localparam logic [RNG_W-1:0]     SEED_NZ   = lfsr_nz(SEED);
    localparam logic [RNG_CNT_W-1:0] STEP_LAST = RNG_CNT_W'(STEP - 1);
    localparam logic [RNG_CNT_W-1:0] IDX_LAST  = RNG_CNT_W'(RNG_NUM_DRAWS - 1);

    rng_state_e           state;
    logic                 start_q;
    logic [RNG_CNT_W-1:0] idx;
    logic [RNG_CNT_W-1:0] step_cnt;
    logic [RNG_W-1:0]     words [RNG_NUM_DRAWS];
    logic                 done;

    logic                 start_rise_c;
    logic                 capture_c;
    logic                 lfsr_en_c;
    logic                 lfsr_load_c;
    logic [RNG_W-1:0]     lfsr_q;
    logic [RNG_W-1:0]     lfsr_next_c;

    assign start_rise_c = bus.start & ~start_q;
    assign capture_c    = (state == FILL) && (step_cnt == STEP_LAST);
    assign lfsr_next_c  = lfsr_step(lfsr_q);

`ifdef RNG_FREE_RUN_EN
    // Button timing supplies entropy: never reload, always advance
    assign lfsr_en_c   = 1'b1;
    assign lfsr_load_c = 1'b0;
`else
    // Repeatable deals: reload at SEED, advance only while filling
    assign lfsr_en_c   = (state == FILL);
    assign lfsr_load_c = (state == rng_pkg::SEED);
`endif

    lfsr16 #(
        .RESET_VAL (SEED_NZ)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (lfsr_en_c),
        .load     (lfsr_load_c),
        .load_val (SEED_NZ),
        .q        (lfsr_q)
    );

    // Deal sequencer, draw counters and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            idx      <= '0;
            step_cnt <= '0;
            done     <= 1'b0;
            for (int unsigned i = 0; i < RNG_NUM_DRAWS; i++) begin
                words[i] <= '0;
            end
        end else begin
            start_q <= bus.start;
            case (state)
                IDLE: begin
                    if (start_rise_c) begin
                        state <= rng_pkg::SEED;
                    end
                end
                rng_pkg::SEED: begin
                    for (int unsigned i = 0; i < RNG_NUM_DRAWS; i++) begin
                        words[i] <= '0;
                    end
                    done     <= 1'b0;
                    idx      <= '0;
                    step_cnt <= '0;
                    state    <= FILL;
                end
                FILL: begin
                    if (capture_c) begin
                        words[idx] <= lfsr_next_c;
                        step_cnt   <= '0;
                        idx        <= idx + RNG_CNT_W'(1);
                        if (idx == IDX_LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        step_cnt <= step_cnt + RNG_CNT_W'(1);
                    end
                end
                DONE: begin
                    if (start_rise_c) begin
                        state <= rng_pkg::SEED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.random_number1 = words[0];
    assign bus.random_number2 = words[1];
    assign bus.random_number3 = words[2];
    assign bus.random_number4 = words[3];
    assign bus.random_number5 = words[4];
    assign bus.random_number6 = words[5];
    assign bus.random_number7 = words[6];
    assign bus.random_number8 = words[7];
    assign bus.random_number9 = words[8];
    assign bus.work_done_rng  = done;

endmodule

// File: tb/tb_rng_bank.sv
// Directed self-checking bench for rng_bank (default build, STEP=3) plus a SEED=0 instance.
module tb_rng_bank;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [15:0] exp_words  [9];
    logic [15:0] first_deal [9];

    rng_bank_if bus ();
    rng_bank_if bus_z ();

    rng_bank #(.SEED(16'hACE1), .STEP(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rng_bank #(.SEED(16'h0000), .STEP(3)) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] tb_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] word_at(input int k);
        case (k)
            0: return bus.random_number1;
            1: return bus.random_number2;
            2: return bus.random_number3;
            3: return bus.random_number4;
            4: return bus.random_number5;
            5: return bus.random_number6;
            6: return bus.random_number7;
            7: return bus.random_number8;
            default: return bus.random_number9;
        endcase
    endfunction

    function automatic logic [15:0] word_at_z(input int k);
        case (k)
            0: return bus_z.random_number1;
            1: return bus_z.random_number2;
            2: return bus_z.random_number3;
            3: return bus_z.random_number4;
            4: return bus_z.random_number5;
            5: return bus_z.random_number6;
            6: return bus_z.random_number7;
            7: return bus_z.random_number8;
            default: return bus_z.random_number9;
        endcase
    endfunction

    function automatic logic [15:0] or_all();
        logic [15:0] acc;
        acc = '0;
        for (int k = 0; k < 9; k++) acc = acc | word_at(k);
        return acc;
    endfunction

    // Rising start sampled at edge E; start drops mid-cycle after E
    task automatic start_edge();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    // Counts edges until done is seen high, bounded
    task automatic wait_done(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.work_done_rng === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        bus.start   = 1'b0;
        bus_z.start = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (or_all() !== 16'h0000) begin
            failures++;
            $display("FAIL reset_words: got %h want 0000", or_all());
        end
        checks++;
        if (bus.work_done_rng !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b want 0", bus.work_done_rng);
        end
        checks++;
        if (dut.u_lfsr.q !== 16'hACE1) begin
            failures++;
            $display("FAIL reset_lfsr: got %h want ace1", dut.u_lfsr.q);
        end
        checks++;
        if (dut_z.u_lfsr.q !== 16'h0001) begin
            failures++;
            $display("FAIL reset_lfsr_seed0: got %h want 0001", dut_z.u_lfsr.q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.work_done_rng !== 1'b0 || or_all() !== 16'h0000) begin
            failures++;
            $display("FAIL idle_after_reset: done=%b words_or=%h want 0/0000", bus.work_done_rng, or_all());
        end
    endtask

    task automatic test_first_deal();
        int n;
        start_edge();
        wait_done(n);
        checks++;
        if (n !== 28) begin
            failures++;
            $display("FAIL first_done_latency: got %0d want 28", n);
        end
        checks++;
        if (bus.random_number1 !== 16'h389C) begin
            failures++;
            $display("FAIL first_rn1: got %h want 389c", bus.random_number1);
        end
        checks++;
        if (bus.random_number2 !== 16'hB313) begin
            failures++;
            $display("FAIL first_rn2: got %h want b313", bus.random_number2);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (word_at(k) !== exp_words[k]) begin
                failures++;
                $display("FAIL first_word%0d: got %h want %h", k + 1, word_at(k), exp_words[k]);
            end
            first_deal[k] = word_at(k);
        end
    endtask

    task automatic test_redraw();
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.work_done_rng !== 1'b1) begin
            failures++;
            $display("FAIL redraw_done_at_E: got %b want 1", bus.work_done_rng);
        end
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.work_done_rng !== 1'b0 || or_all() !== 16'h0000) begin
            failures++;
            $display("FAIL redraw_clear: done=%b words_or=%h want 0/0000", bus.work_done_rng, or_all());
        end
        wait_done(n);
        checks++;
        if (n !== 27) begin
            failures++;
            $display("FAIL redraw_latency: got %0d want 27 after E+1", n);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (word_at(k) !== exp_words[k]) begin
                failures++;
                $display("FAIL redraw_word%0d: got %h want %h", k + 1, word_at(k), exp_words[k]);
            end
        end
    endtask

    task automatic test_start_held();
        int first;
        int lows_after;
        first      = -1;
        lows_after = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (first < 0 && bus.work_done_rng === 1'b1) first = c;
            if (first >= 0 && bus.work_done_rng !== 1'b1) lows_after++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (first !== 28) begin
            failures++;
            $display("FAIL held_done_cycle: got %0d want 28", first);
        end
        checks++;
        if (lows_after !== 0) begin
            failures++;
            $display("FAIL held_single_deal: done low cycles after rise got %0d want 0", lows_after);
        end
        checks++;
        if (bus.random_number9 !== exp_words[8]) begin
            failures++;
            $display("FAIL held_rn9: got %h want %h", bus.random_number9, exp_words[8]);
        end
    endtask

    task automatic test_mid_fill_pulse();
        int n;
        start_edge();
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        wait_done(n);
        checks++;
        if (n + 11 !== 28) begin
            failures++;
            $display("FAIL midfill_latency: got %0d want 28", n + 11);
        end
        checks++;
        if (bus.random_number1 !== exp_words[0] || bus.random_number9 !== exp_words[8]) begin
            failures++;
            $display("FAIL midfill_words: rn1=%h rn9=%h want %h %h", bus.random_number1, bus.random_number9, exp_words[0], exp_words[8]);
        end
        start_edge();
        @(posedge clk);
        #1;
        checks++;
        if (bus.work_done_rng !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_redraw: done got %b want 0", bus.work_done_rng);
        end
        wait_done(n);
        checks++;
        if (n !== 27) begin
            failures++;
            $display("FAIL done_pulse_latency: got %0d want 27 after E+1", n);
        end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        start_edge();
        repeat (16) @(posedge clk);
        #1;
        checks++;
        if (bus.random_number5 !== exp_words[4] || bus.random_number6 !== 16'h0000) begin
            failures++;
            $display("FAIL fifth_capture: rn5=%h rn6=%h want %h 0000", bus.random_number5, bus.random_number6, exp_words[4]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (or_all() !== 16'h0000 || bus.work_done_rng !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: words_or=%h done=%b want 0000/0", or_all(), bus.work_done_rng);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_edge();
        wait_done(n);
        checks++;
        if (n !== 28 || bus.random_number1 !== 16'h389C) begin
            failures++;
            $display("FAIL post_reset_deal: latency=%0d rn1=%h want 28 389c", n, bus.random_number1);
        end
    endtask

    task automatic test_seed_zero();
        int zeros;
        int timeouts;
        int n;
        zeros    = 0;
        timeouts = 0;
        for (int d = 0; d < 1000; d++) begin
            @(negedge clk);
            bus_z.start = 1'b1;
            @(posedge clk);
            #2;
            bus_z.start = 1'b0;
            n = 0;
            while (n < 60) begin
                @(posedge clk);
                #1;
                n++;
                if (bus_z.work_done_rng === 1'b1) break;
            end
            if (n >= 60) timeouts++;
            for (int k = 0; k < 9; k++) begin
                if (word_at_z(k) === 16'h0000) zeros++;
            end
            if (d == 0) begin
                checks++;
                if (bus_z.random_number1 !== 16'h2D00) begin
                    failures++;
                    $display("FAIL seed0_rn1: got %h want 2d00", bus_z.random_number1);
                end
            end
        end
        checks++;
        if (zeros !== 0) begin
            failures++;
            $display("FAIL seed0_no_zero: zero words got %0d want 0", zeros);
        end
        checks++;
        if (timeouts !== 0) begin
            failures++;
            $display("FAIL seed0_timeouts: got %0d want 0", timeouts);
        end
    endtask

    initial begin
        logic [15:0] v;
        checks   = 0;
        failures = 0;
        v = 16'hACE1;
        for (int k = 0; k < 9; k++) begin
            for (int s = 0; s < 3; s++) v = tb_next(v);
            exp_words[k] = v;
        end
        test_reset();
        test_first_deal();
        test_redraw();
        test_start_held();
        test_mid_fill_pulse();
        test_reset_mid_fill();
        test_seed_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
